sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single external async SRAM (19-bit addr, 8-bit data) between two requesters.
//  Port A: Oric core RAM port (priority). Port B: auxiliary master (disk/tape image buffer).
//  Sequences each access as a fixed-length SRAM cycle and owns sramA/sramWe/sramDQ drive.
//  Top level builds the tristate: sramDQ = sram_dq_oe ? sram_dq_o : 8'bZ.
// PARAMETERS
//  ADDR_W         19        SRAM address width
//  ACCESS_CYCLES  2         clocks the SRAM address/strobe are held per access (>=1)
//  STARVE_MAX     8         consecutive A grants while b_req is high before B is forced
//  WP_BASE        19'h0C000 lowest write-protected address (SRAM_WP_EN only)
// PORTS
//  clk_sys     in   1       system clock
//  reset_n     in   1       reset, asynchronous, active-low
//  a_req       in   1       port A request; level, held until a_ack
//  a_we        in   1       1 = write, 0 = read
//  a_addr      in   ADDR_W  port A address
//  a_wdata     in   8       port A write data
//  a_rdata     out  8       port A read data; valid while a_ack = 1, held until next A read
//  a_ack       out  1       one-cycle completion pulse
//  b_req, b_we, b_addr, b_wdata, b_rdata, b_ack   as port A, for port B
//  sram_a      out  ADDR_W  SRAM address
//  sram_we_n   out  1       SRAM write strobe, active-low
//  sram_dq_o   out  8       SRAM write data
//  sram_dq_oe  out  1       SRAM data drive enable
//  sram_dq_i   in   8       SRAM read data
//  busy        out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; sram_a=0, sram_we_n=1, sram_dq_o=0, sram_dq_oe=0,
//   a_ack=b_ack=0, a_rdata=b_rdata=0, starve_cnt=0, busy=0. Assertion mid-access aborts
//   immediately: no ack, sram_we_n high and sram_dq_oe low on the reset edge.
//  FSM: IDLE -> ACC (ACCESS_CYCLES clocks) -> DONE (1 clock) -> IDLE.
//  IDLE arbitration, evaluated once per IDLE clock:
//   - b_req & (starve_cnt==STARVE_MAX): grant B. Else a_req: grant A. Else b_req: grant B.
//   - starve_cnt: +1 on an A grant while b_req=1 (saturates); cleared on B grant or b_req=0.
//  Grant edge latches addr/we/wdata of the winner into sram_a/sram_dq_o; all outputs registered.
//  ACC write: sram_dq_oe=1 and sram_we_n=0 for all ACCESS_CYCLES clocks.
//  ACC read: sram_we_n=1, sram_dq_oe=0; sram_dq_i captured on the final ACC clock into rdata.
//  DONE: granted port's ack=1 for exactly this clock; sram_we_n=1; sram_dq_oe stays 1 for
//   writes (data hold after WE rising), 0 otherwise; sram_a held.
//  Latency: ack high ACCESS_CYCLES+1 clocks after the IDLE edge that sampled req.
//  Throughput: one access per ACCESS_CYCLES+2 clocks; A and B never overlap.
//  Handshake: requester drops req on the clock after seeing ack; req still high in following
//   IDLE = new access. Addr/we/wdata changes after grant are ignored until next grant.
//  req dropped mid-access: access completes, ack still pulsed.
//  Simultaneous a_req & b_req with starve_cnt<STARVE_MAX: A wins; B waits.
//  The port that does not own the access never sees ack and its rdata is unchanged.
// CONFIGURATION
//  SRAM_WP_EN defined: writes (either port) with addr >= WP_BASE run the full FSM and get
//   ack, but sram_we_n stays 1 and sram_dq_oe stays 0 (ROM shadow protection).
//  SRAM_WP_EN undefined: WP_BASE unused; all writes reach the SRAM.
// TESTING
//  Reset during write ACC -> sram_we_n=1, sram_dq_oe=0 same edge; no ack after release.
//  A read 0x00123, SRAM model returns 0x5A -> sram_a=0x00123, a_ack 3 clks later, a_rdata=0x5A.
//  B write 0x7FFFF<-0xC3 -> sram_we_n low exactly 2 clks, dq_oe low 1 clk after WE rises.
//  a_req held permanently + b_req -> B granted after exactly 8 A accesses, then A resumes.
//  Same-cycle a_req/b_req, starve_cnt=0 -> A acks first, B ack 4 clks later; no overlap.
//  SRAM_WP_EN: A write 0x0C000<-0xFF -> a_ack pulses, sram_we_n never low, memory unchanged.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external async SRAM (ADDR_W-bit address, 8-bit data)
// between port A (Oric core RAM, priority) and port B (aux disk/tape buffer).
// Each access runs IDLE -> ACC (ACCESS_CYCLES clocks) -> DONE (1 clock) -> IDLE.
// Optional feature macro: SRAM_WP_EN - writes at addr >= WP_BASE complete and ack
// but never strobe the SRAM (ROM shadow protection).
// Ports:
//   clk_sys, reset_n                 clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata        port A request (level, held until a_ack)
//   a_rdata/a_ack                    port A read data (held) / one-clock done pulse
//   b_*                              same as port A, for port B
//   sram_a/sram_we_n/sram_dq_o       SRAM address, write strobe, write data
//   sram_dq_oe/sram_dq_i             data drive enable (top builds tristate), read data
//   busy                             access in progress (state != IDLE)
module sram_arbiter #(
    parameter int unsigned     ADDR_W        = 19,
    parameter int unsigned     ACCESS_CYCLES = 2,
    parameter int unsigned     STARVE_MAX    = 8,
    parameter logic [ADDR_W-1:0] WP_BASE     = ADDR_W'(20'h0C000)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata,
    output logic              b_ack,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_we_n,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              busy
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);
`ifdef SRAM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic              sel_b_q, sel_b_d;    // owner of the current access
    logic              wr_q, wr_d;          // current access is a write
    logic              drive_q, drive_d;    // write actually reaches the SRAM
    logic [ADDR_W-1:0] sram_a_d;
    logic              sram_we_n_d, sram_dq_oe_d, a_ack_d, b_ack_d, busy_d;
    logic [7:0]        sram_dq_o_d, a_rdata_d, b_rdata_d;
    logic              grant_a, grant_b, win_we, wp_hit;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_wdata;

    // State and output registers; reset aborts any access with strobes released
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            acc_cnt_q  <= '0;
            starve_q   <= '0;
            sel_b_q    <= 1'b0;
            wr_q       <= 1'b0;
            drive_q    <= 1'b0;
            sram_a     <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            starve_q   <= starve_d;
            sel_b_q    <= sel_b_d;
            wr_q       <= wr_d;
            drive_q    <= drive_d;
            sram_a     <= sram_a_d;
            sram_we_n  <= sram_we_n_d;
            sram_dq_o  <= sram_dq_o_d;
            sram_dq_oe <= sram_dq_oe_d;
            a_ack      <= a_ack_d;
            b_ack      <= b_ack_d;
            a_rdata    <= a_rdata_d;
            b_rdata    <= b_rdata_d;
            busy       <= busy_d;
        end
    end

    // Arbitration, access sequencing and next output values
    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        starve_d     = starve_q;
        sel_b_d      = sel_b_q;
        wr_d         = wr_q;
        drive_d      = drive_q;
        sram_a_d     = sram_a;
        sram_we_n_d  = 1'b1;
        sram_dq_o_d  = sram_dq_o;
        sram_dq_oe_d = 1'b0;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata;
        b_rdata_d    = b_rdata;

        // B wins when starved, or when A is not asking
        grant_b   = b_req && ((starve_q == ST_MAX) || !a_req);
        grant_a   = a_req && !grant_b;
        win_we    = grant_b ? b_we    : a_we;
        win_addr  = grant_b ? b_addr  : a_addr;
        win_wdata = grant_b ? b_wdata : a_wdata;
        wp_hit    = WP_EN && win_we && (win_addr >= WP_BASE);

        case (state_q)
            S_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d      = S_ACC;
                    acc_cnt_d    = '0;
                    sel_b_d      = grant_b;
                    wr_d         = win_we;
                    drive_d      = win_we && !wp_hit;
                    sram_a_d     = win_addr;
                    sram_dq_o_d  = win_wdata;
                    sram_we_n_d  = !(win_we && !wp_hit);
                    sram_dq_oe_d = win_we && !wp_hit;
                    if (grant_b)
                        starve_d = '0;
                    else if (b_req && (starve_q != ST_MAX))
                        starve_d = starve_q + ST_W'(1);
                end
            end
            S_ACC: begin
                sram_we_n_d  = !drive_q;
                sram_dq_oe_d = drive_q;
                if (acc_cnt_q == ACC_LAST) begin
                    // Strobe rises into DONE; data keeps driving one more clock
                    state_d     = S_DONE;
                    sram_we_n_d = 1'b1;
                    a_ack_d     = !sel_b_q;
                    b_ack_d     = sel_b_q;
                    if (!wr_q) begin
                        if (sel_b_q) b_rdata_d = sram_dq_i;
                        else         a_rdata_d = sram_dq_i;
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!b_req)
            starve_d = '0;

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we;
    logic [18:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic [7:0]  a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [18:0] sram_a;
    logic        sram_we_n, sram_dq_oe, busy;
    logic [7:0]  sram_dq_o, sram_dq_i;

    logic [7:0]  mem [0:524287];
    logic        pl_en;
    logic [18:0] pl_addr;
    logic [7:0]  pl_data;

    int n_cmp  = 0;
    int n_fail = 0;

    sram_arbiter dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_rdata    (a_rdata),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_rdata    (b_rdata),
        .b_ack      (b_ack),
        .sram_a     (sram_a),
        .sram_we_n  (sram_we_n),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Async SRAM model: combinational read, write while strobe and drive are active
    assign sram_dq_i = mem[sram_a];
    always @(posedge clk_sys) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (!sram_we_n && sram_dq_oe)
            mem[sram_a] <= sram_dq_o;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic preload(input logic [18:0] addr, input logic [7:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        step();
        pl_en   = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (sram_a !== 19'h0)   begin n_fail++; $display("FAIL reset_sram_a got %h want 00000", sram_a); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe got %b want 0", sram_dq_oe); end
        n_cmp++; if (sram_dq_o !== 8'h00) begin n_fail++; $display("FAIL reset_dq_o got %h want 00", sram_dq_o); end
        n_cmp++; if ({a_ack, b_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got %b want 00", {a_ack, b_ack}); end
        n_cmp++; if ({a_rdata, b_rdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", {a_rdata, b_rdata}); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_read_a();
        a_we = 1'b0; a_addr = 19'h00123; a_req = 1'b1;
        step();  // grant edge
        n_cmp++; if (sram_a !== 19'h00123) begin n_fail++; $display("FAIL rd_a_addr got %h want 00123", sram_a); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_a_busy got %b want 1", busy); end
        a_addr = 19'h00456;  // must be ignored until next grant
        step();
        n_cmp++; if (sram_a !== 19'h00123) begin n_fail++; $display("FAIL rd_a_addr_hold got %h want 00123", sram_a); end
        n_cmp++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL rd_a_early_ack got %b want 0", a_ack); end
        step();
        n_cmp++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL rd_a_ack got %b want 1", a_ack); end
        n_cmp++; if (a_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_a_data got %h want 5a", a_rdata); end
        n_cmp++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL rd_a_b_ack got %b want 0", b_ack); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rd_a_we_n got %b want 1", sram_we_n); end
        a_req = 1'b0;
        step();
        n_cmp++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL rd_a_ack_pulse got %b want 0", a_ack); end
        n_cmp++; if (a_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_a_data_hold got %h want 5a", a_rdata); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_a_idle got %b want 0", busy); end
    endtask

    task automatic test_write_b();
        b_we = 1'b1; b_addr = 19'h7FFFF; b_wdata = 8'hC3; b_req = 1'b1;
        step();
        n_cmp++; if ({sram_we_n, sram_dq_oe} !== 2'b01) begin n_fail++; $display("FAIL wr_b_strobe0 got %b want 01", {sram_we_n, sram_dq_oe}); end
        n_cmp++; if ({sram_a, sram_dq_o} !== {19'h7FFFF, 8'hC3}) begin n_fail++; $display("FAIL wr_b_bus got %h/%h want 7ffff/c3", sram_a, sram_dq_o); end
        step();
        n_cmp++; if ({sram_we_n, sram_dq_oe} !== 2'b01) begin n_fail++; $display("FAIL wr_b_strobe1 got %b want 01", {sram_we_n, sram_dq_oe}); end
        step();
        n_cmp++; if ({sram_we_n, sram_dq_oe} !== 2'b11) begin n_fail++; $display("FAIL wr_b_hold got %b want 11", {sram_we_n, sram_dq_oe}); end
        n_cmp++; if ({a_ack, b_ack} !== 2'b01) begin n_fail++; $display("FAIL wr_b_ack got %b want 01", {a_ack, b_ack}); end
        b_req = 1'b0;
        step();
        n_cmp++; if ({sram_we_n, sram_dq_oe} !== 2'b10) begin n_fail++; $display("FAIL wr_b_release got %b want 10", {sram_we_n, sram_dq_oe}); end
        n_cmp++; if (mem[19'h7FFFF] !== 8'hC3) begin n_fail++; $display("FAIL wr_b_mem got %h want c3", mem[19'h7FFFF]); end
        n_cmp++; if ({a_rdata, b_rdata} !== 16'h5A00) begin n_fail++; $display("FAIL wr_b_rdata got %h want 5a00", {a_rdata, b_rdata}); end
        step();
    endtask

    task automatic test_simultaneous();
        int a_cyc = -1;
        int b_cyc = -1;
        int overlap = 0;
        a_we = 1'b0; a_addr = 19'h00010;
        b_we = 1'b0; b_addr = 19'h00020;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (a_ack && b_ack) overlap++;
            if (a_ack && a_cyc < 0) begin a_cyc = c; a_req = 1'b0; end
            if (b_ack && b_cyc < 0) begin b_cyc = c; b_req = 1'b0; end
            if (a_cyc > 0 && b_cyc > 0) break;
        end
        n_cmp++; if (a_cyc !== 3) begin n_fail++; $display("FAIL sim_a_cycle got %0d want 3", a_cyc); end
        n_cmp++; if (b_cyc !== 7) begin n_fail++; $display("FAIL sim_b_cycle got %0d want 7", b_cyc); end
        n_cmp++; if (overlap !== 0) begin n_fail++; $display("FAIL sim_overlap got %0d want 0", overlap); end
        n_cmp++; if ({a_rdata, b_rdata} !== 16'h1122) begin n_fail++; $display("FAIL sim_rdata got %h want 1122", {a_rdata, b_rdata}); end
        a_req = 1'b0; b_req = 1'b0;
        step(); step();
    endtask

    task automatic test_starve();
        int n_a = 0;
        int b_seen = 0;
        int resume = -1;
        a_we = 1'b0; a_addr = 19'h00030;
        b_we = 1'b0; b_addr = 19'h00040;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (a_ack) n_a++;
            if (b_ack) begin b_seen = 1; b_req = 1'b0; break; end
        end
        n_cmp++; if (b_seen !== 1) begin n_fail++; $display("FAIL starve_b_timeout got %0d want 1", b_seen); end
        n_cmp++; if (n_a !== 8) begin n_fail++; $display("FAIL starve_a_count got %0d want 8", n_a); end
        n_cmp++; if ({a_rdata, b_rdata} !== 16'h3344) begin n_fail++; $display("FAIL starve_rdata got %h want 3344", {a_rdata, b_rdata}); end
        for (int c = 1; c <= 8; c++) begin
            step();
            if (a_ack) begin resume = c; break; end
        end
        n_cmp++; if (resume !== 4) begin n_fail++; $display("FAIL starve_a_resume got %0d want 4", resume); end
        a_req = 1'b0;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        a_we = 1'b1; a_addr = 19'h00050; a_wdata = 8'h77; a_req = 1'b1;
        step();
        n_cmp++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we_active got %b want 0", sram_we_n); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({sram_we_n, sram_dq_oe} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_strobes got %b want 10", {sram_we_n, sram_dq_oe}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        a_req = 1'b0;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (a_ack || b_ack) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack got %0d want 0", acks); end
    endtask

    task automatic test_wp();
        int we_low = 0;
        int acked = 0;
        a_we = 1'b1; a_addr = 19'h0C000; a_wdata = 8'hFF; a_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (!sram_we_n) we_low++;
            if (a_ack) begin acked++; a_req = 1'b0; end
            if (acked > 0 && !busy) break;
        end
        n_cmp++; if (acked !== 1) begin n_fail++; $display("FAIL wp_ack got %0d want 1", acked); end
`ifdef SRAM_WP_EN
        n_cmp++; if (we_low !== 0) begin n_fail++; $display("FAIL wp_we_low got %0d want 0", we_low); end
        n_cmp++; if (mem[19'h0C000] !== 8'h12) begin n_fail++; $display("FAIL wp_mem got %h want 12", mem[19'h0C000]); end
`else
        n_cmp++; if (we_low !== 2) begin n_fail++; $display("FAIL wp_we_low got %0d want 2", we_low); end
        n_cmp++; if (mem[19'h0C000] !== 8'hFF) begin n_fail++; $display("FAIL wp_mem got %h want ff", mem[19'h0C000]); end
`endif
        a_req = 1'b0;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        step();
        preload(19'h00123, 8'h5A);
        preload(19'h00010, 8'h11);
        preload(19'h00020, 8'h22);
        preload(19'h00030, 8'h33);
        preload(19'h00040, 8'h44);
        preload(19'h0C000, 8'h12);
        preload(19'h7FFFF, 8'h00);
        test_reset();
        #3 reset_n = 1'b1;
        step();
        test_reset();
        test_read_a();
        test_write_b();
        test_simultaneous();
        test_starve();
        test_reset_mid_write();
        test_wp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
